// File: rtl/regfile_stream_reader_if.sv
// Bundle of the regfile read port and the val/rdy output stream used by
// regfile_stream_reader.
//
// master : the stream reader. It drives rf_raddr, out_val, out_data and
//          out_addr, and receives rf_rdata and out_rdy.
// slave  : the regfile and consumer side, with the opposite directions.
//
// rf_raddr  AW     regfile read address
// rf_rdata  NBITS  regfile read data, combinational from rf_raddr
// out_val   1      output word valid
// out_rdy   1      consumer ready
// out_data  NBITS  streamed word
// out_addr  AW     address the streamed word was read from
interface regfile_stream_reader_if #(
    parameter int NBITS  = 4,
    parameter int NWORDS = 4
);
    localparam int AW = $clog2(NWORDS);

    logic [AW-1:0]    rf_raddr;
    logic [NBITS-1:0] rf_rdata;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_data;
    logic [AW-1:0]    out_addr;

    modport master (
        output rf_raddr,
        input  rf_rdata,
        output out_val,
        input  out_rdy,
        output out_data,
        output out_addr
    );

    modport slave (
        input  rf_raddr,
        output rf_rdata,
        input  out_val,
        output out_rdy,
        input  out_data,
        input  out_addr
    );
endinterface

// File: rtl/regfile_stream_reader.sv
// Read-side initiator for a 1r1w register file. A start command sets up a
// contiguous, wrapping address range. Each word read from that range is
// captured in a one-entry buffer and streamed out on a val/rdy interface.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   start        start command, sampled only while idle
//   start_base   first address to read
//   start_count  number of words to stream (0 .. 2*NWORDS-1)
//   busy         high whenever the reader is not idle
//   done         one-cycle pulse when the stream completes
//   bus          regfile read port and output stream (master side)
//   sum          (only with REGFILE_STREAM_READER_SUM_EN) modulo-2^NBITS sum
//                of the words transferred in the current stream
//
// Optional feature macro: REGFILE_STREAM_READER_SUM_EN
module regfile_stream_reader #(
    parameter int NBITS  = 4,
    parameter int NWORDS = 4,
    localparam int AW    = $clog2(NWORDS),
    localparam int CW    = AW + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [AW-1:0]                  start_base,
    input  logic [CW-1:0]                  start_count,
    output logic                           busy,
    output logic                           done,
`ifdef REGFILE_STREAM_READER_SUM_EN
    output logic [NBITS-1:0]               sum,
`endif
    regfile_stream_reader_if.master        bus
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    addr;
    logic [CW-1:0]    remaining;
    logic             obuf_val;
    logic [NBITS-1:0] obuf_data;
    logic [AW-1:0]    obuf_addr;

    // The buffer can accept a new word when it is empty or is being
    // drained in this same cycle.
    logic buf_free;
    logic fetch;
    logic launch;

    assign buf_free = !obuf_val || bus.out_rdy;
    assign fetch    = (state == READ) && (remaining != '0) && buf_free;
    assign launch   = (state == IDLE) && start && (start_count != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. READ ends in the cycle its last word is handed
    // over, so DONE always sees an empty buffer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (start_count != '0) ? READ : DONE;
                end
            end
            READ: begin
                if ((remaining == '0) && buf_free) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Address walker and output buffer. The address relies on natural
    // AW-bit wraparound, which is why NWORDS must be a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            obuf_val  <= 1'b0;
            obuf_data <= '0;
            obuf_addr <= '0;
        end else begin
            if (launch) begin
                addr      <= start_base;
                remaining <= start_count;
            end
            if (fetch) begin
                obuf_data <= bus.rf_rdata;
                obuf_addr <= addr;
                obuf_val  <= 1'b1;
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end else if ((state == READ) && obuf_val && bus.out_rdy) begin
                obuf_val <= 1'b0;
            end
        end
    end

    assign bus.rf_raddr = addr;
    assign bus.out_val  = obuf_val;
    assign bus.out_data = obuf_data;
    assign bus.out_addr = obuf_addr;

`ifdef REGFILE_STREAM_READER_SUM_EN
    // Running sum of transferred words. It is cleared on any accepted
    // start, including a zero-length one, and holds after the stream ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if ((state == IDLE) && start) begin
            sum <= '0;
        end else if (obuf_val && bus.out_rdy) begin
            sum <= sum + obuf_data;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Directed testbench for regfile_stream_reader with NBITS=4, NWORDS=4.
// The regfile is modelled as an array with a combinational read. For every
// accepted start, a queue is filled with the (address, data) words the
// stream must deliver. A compare process checks the output stream against
// that queue on every cycle. Hand-computed literal checks pin down reset
// values, latency, wrap, stall hold and reset abort.
module tb_regfile_stream_reader;

    localparam int NBITS  = 4;
    localparam int NWORDS = 4;
    localparam int AW     = $clog2(NWORDS);
    localparam int CW     = AW + 1;

    typedef struct {
        int addr;
        int data;
    } word_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_base;
    logic [CW-1:0] start_count;
    logic          busy;
    logic          done;
`ifdef REGFILE_STREAM_READER_SUM_EN
    logic [NBITS-1:0] sum;
`endif

    logic [NBITS-1:0] rf [NWORDS];

    int    nvec;
    int    nmis;
    word_t expq[$];
    int    exp_sum;

    regfile_stream_reader_if #(.NBITS(NBITS), .NWORDS(NWORDS)) bus ();

    regfile_stream_reader #(.NBITS(NBITS), .NWORDS(NWORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_base  (start_base),
        .start_count (start_count),
        .busy        (busy),
        .done        (done),
`ifdef REGFILE_STREAM_READER_SUM_EN
        .sum         (sum),
`endif
        .bus         (bus)
    );

    assign bus.rf_rdata = rf[bus.rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nvec++;
        if (actual != expected) begin
            nmis++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Wait for the reader to be idle, issue a start, and record the
    // expected stream: count words from base upward, wrapping mod NWORDS.
    task automatic applyStimulus(input int base, input int count);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (busy) checkOutput("idle_timeout", 1, 0);
        start       = 1'b1;
        start_base  = AW'(base);
        start_count = CW'(count);
        @(posedge clk);
        #1;
        start   = 1'b0;
        exp_sum = 0;
        for (int i = 0; i < count; i++) begin
            word_t w;
            w.addr = (base + i) % NWORDS;
            w.data = int'(rf[w.addr]);
            expq.push_back(w);
        end
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream checker. It compares each presented word with the head of the
    // expected queue, and pops the head when the consumer takes the word.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            exp_sum = 0;
        end else begin
            if (bus.out_val) begin
                if (expq.size() == 0) begin
                    checkOutput("spurious_val", 1, 0);
                end else begin
                    checkOutput("stream_data", int'(bus.out_data), expq[0].data);
                    checkOutput("stream_addr", int'(bus.out_addr), expq[0].addr);
                    if (bus.out_rdy) begin
                        exp_sum = (exp_sum + expq[0].data) % (1 << NBITS);
                        void'(expq.pop_front());
                    end
                end
            end
            if (done) begin
                checkOutput("done_drained", expq.size(), 0);
`ifdef REGFILE_STREAM_READER_SUM_EN
                checkOutput("sum_model", int'(sum), exp_sum);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] lit_d [4];
        logic [3:0] wrap_d [3];
        int         wrap_a [3];

        lit_d  = '{4'hA, 4'h3, 4'h7, 4'hF};
        wrap_d = '{4'hF, 4'hA, 4'h3};
        wrap_a = '{3, 0, 1};

        nvec        = 0;
        nmis        = 0;
        exp_sum     = 0;
        rf[0]       = 4'hA;
        rf[1]       = 4'h3;
        rf[2]       = 4'h7;
        rf[3]       = 4'hF;
        rst         = 1'b1;
        start       = 1'b0;
        start_base  = '0;
        start_count = '0;
        bus.out_rdy = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_val", int'(bus.out_val), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_out_data", int'(bus.out_data), 0);
        checkOutput("rst_out_addr", int'(bus.out_addr), 0);
        checkOutput("rst_rf_raddr", int'(bus.rf_raddr), 0);
`ifdef REGFILE_STREAM_READER_SUM_EN
        checkOutput("rst_sum", int'(sum), 0);
`endif
        rst = 1'b0;

        // Full stream with the consumer always ready
        applyStimulus(0, 4);
        @(negedge clk);
        checkOutput("t1_busy", int'(busy), 1);
        checkOutput("t1_val_early", int'(bus.out_val), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t1_val", int'(bus.out_val), 1);
            checkOutput("t1_data", int'(bus.out_data), int'(lit_d[i]));
            checkOutput("t1_addr", int'(bus.out_addr), i);
        end
        @(negedge clk);
        checkOutput("t1_done", int'(done), 1);
        checkOutput("t1_val_after", int'(bus.out_val), 0);
`ifdef REGFILE_STREAM_READER_SUM_EN
        checkOutput("t1_sum", int'(sum), 3);
`endif
        @(negedge clk);
        checkOutput("t1_idle", int'(busy), 0);
        checkOutput("t1_done_pulse", int'(done), 0);

        // Wrapping stream
        applyStimulus(3, 3);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t2_data", int'(bus.out_data), int'(wrap_d[i]));
            checkOutput("t2_addr", int'(bus.out_addr), wrap_a[i]);
        end
        @(negedge clk);
        checkOutput("t2_done", int'(done), 1);

        // Zero-length stream
        applyStimulus(1, 0);
        @(negedge clk);
        checkOutput("t3_done", int'(done), 1);
        checkOutput("t3_busy", int'(busy), 1);
        checkOutput("t3_val", int'(bus.out_val), 0);
`ifdef REGFILE_STREAM_READER_SUM_EN
        checkOutput("t3_sum", int'(sum), 0);
`endif
        @(negedge clk);
        checkOutput("t3_done_off", int'(done), 0);
        checkOutput("t3_busy_off", int'(busy), 0);

        // Back-pressure while word 0x3 is presented, plus an ignored start
        applyStimulus(0, 4);
        tick();
        tick();
        bus.out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t4_hold_val", int'(bus.out_val), 1);
            checkOutput("t4_hold_data", int'(bus.out_data), 3);
            checkOutput("t4_hold_addr", int'(bus.out_addr), 1);
            if (k == 1) begin
                start       = 1'b1;
                start_base  = 2'd2;
                start_count = 3'd1;
            end
            tick();
            start = 1'b0;
        end
        bus.out_rdy = 1'b1;
        waitDone();

        // Reset in the middle of a stream
        applyStimulus(0, 4);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_val", int'(bus.out_val), 0);
        checkOutput("t5_busy", int'(busy), 0);
        checkOutput("t5_done", int'(done), 0);
        applyStimulus(2, 2);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_first", int'(bus.out_data), 7);
        @(negedge clk);
        checkOutput("t5_second", int'(bus.out_data), 4'hF);
        waitDone();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
